commit_trace_unit: RTL and testbench
====================================

Name: commit_trace_unit

Overview:
- Synthesizable commit-event producer inside proc_hier, the writer side of the commit/trace interface that the processor bench consumes.
- Watches per-cycle retire signals (register write, load, store, halt) and cache request/hit strobes, packs them into fixed-format trace records and buffers them in a FIFO. Records leave on a valid/ready stream.
- On halt, the unit drains the FIFO, emits a halt record, then emits statistics records (cycles, instructions, cache counts), then parks in DONE.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, at least 4.
- CNT_W, 32, width of each statistics counter; fixed at 32 for stat record encoding.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- RegWrite  in  1  register file written this cycle
- WriteRegister  in  3  destination register
- WriteData  in  16  register write data
- MemRead  in  1  load in memory stage
- MemWrite  in  1  store in memory stage
- MemAddress  in  16  memory address
- MemDataIn  in  16  store data
- MemDataOut  in  16  load data
- Halt  in  1  halt retiring this cycle
- ICacheReq, ICacheHit, DCacheReq, DCacheHit  in  1 each  cache strobes
- trace_valid  out  1  record available
- trace_ready  in  1  consumer accepts record
- trace_type  out  3  0 REG, 1 LOAD, 2 STORE, 3 HALT, 4 STAT
- trace_addr  out  16  record address/index field
- trace_data  out  16  record data field
- overflow  out  1  sticky: records were dropped
- done  out  1  all records emitted

Behaviour:
- Reset (any state): state=RUN, FIFO empty, all counters 0, drop_count 0. Outputs after reset: trace_valid 0, overflow 0, done 0, type/addr/data 0.
- FSM states: RUN, DRAIN, HALTREC, STATS, DONE.
- RUN
  - Each cycle builds 0–3 records, in this order: REG {addr={13'b0,WriteRegister}, data=WriteData}, LOAD {MemAddress, MemDataOut}, STORE {MemAddress, MemDataIn}.
  - All records from one cycle are written in the same posedge, only if free slots ≥ record count.
  - Otherwise none of that cycle's records are written, overflow is set (sticky), and drop_count (16-bit, saturating) increments by 1 per dropped cycle.
  - A pop in the same cycle does not add free space for that cycle's push. Free space is evaluated before the pop.
  - Written record appears at the FIFO head no earlier than the next cycle; minimum latency is 1 cycle.
  - Counters update every RUN cycle, including the halt cycle:
    - cycles +1.
    - inst +1 if Halt|RegWrite|MemWrite.
    - Each cache counter +1 on its strobe.
    - All counters wrap at 2^32.
  - Halt=1 → DRAIN after this cycle's records are processed.
- DRAIN: inputs ignored, counters frozen. FIFO pops on valid&&ready. FIFO empty → HALTREC.
- HALTREC: one record {type 3, addr 0, data drop_count}. On ready → STATS.
- STATS
  - 12 records, type 4, index order 0 cycles, 1 inst, 2 dchit, 3 ichit, 4 dcreq, 5 icreq.
  - Each index emits the upper half first, then the lower half.
  - addr={12'b0, idx[2:0], half} with half 1=upper; data = that half.
  - After the 12th is accepted → DONE.
- DONE: trace_valid 0, done 1. Stays until rst.
- Stream rules:
  - In RUN/DRAIN, output comes from the FIFO head; in HALTREC/STATS, from the FSM.
  - While trace_valid && !trace_ready, type/addr/data stay stable and valid stays high.
  - Transfer occurs on posedge with valid && ready.
- Wrap-around: FIFO read/write pointers wrap modulo DEPTH. Full is distinguished from empty by occupancy count.

Test Plan:
- RegWrite=1, WriteRegister=3, WriteData=0xBEEF, ready=1 → next cycle valid=1, type 0, addr 0x0003, data 0xBEEF; valid drops the cycle after.
- Same cycle RegWrite(r1,0x1111) + MemRead(addr 0x0040, out 0x2222) + MemWrite(addr 0x0042, in 0x3333) → three consecutive records, in order REG/LOAD/STORE, with those values.
- ready=0, DEPTH=8, three-record cycles ×3 → 6 entries stored; third cycle dropped and overflow=1. Then Halt, ready=1 → 6 FIFO records, then HALT record with data 0x0001.
- From reset:
  - Stimulus: 4 cycles with RegWrite, 1 idle, then Halt; ICacheReq every cycle, ICacheHit on 3 of them.
  - Required HALT data 0x0000.
  - STAT lower halves: cycles=6, inst=5, ichit=3, icreq=6, dchit=0, dcreq=0; all upper halves 0.
- During STATS hold ready=0 for 3 cycles → record unchanged and valid held; released → sequence resumes without loss. done=1 after record 12.
- Assert rst in STATS → next cycle valid=0, done=0, overflow=0; a following RegWrite yields a normal REG record and restarts counters at 0.

Source files
------------

// File: rtl/commit_trace_unit_if.sv
// Commit/trace interface: per-cycle retire and cache strobes flow into the
// trace unit, and packed trace records flow out on a valid/ready stream.
interface commit_trace_unit_if;
    logic        RegWrite;
    logic [2:0]  WriteRegister;
    logic [15:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [15:0] MemAddress;
    logic [15:0] MemDataIn;
    logic [15:0] MemDataOut;
    logic        Halt;
    logic        ICacheReq;
    logic        ICacheHit;
    logic        DCacheReq;
    logic        DCacheHit;
    logic        trace_valid;
    logic        trace_ready;
    logic [2:0]  trace_type;
    logic [15:0] trace_addr;
    logic [15:0] trace_data;

    // Processor/bench side: drives retire events, consumes the trace stream.
    modport master (
        output RegWrite, WriteRegister, WriteData, MemRead, MemWrite,
               MemAddress, MemDataIn, MemDataOut, Halt,
               ICacheReq, ICacheHit, DCacheReq, DCacheHit, trace_ready,
        input  trace_valid, trace_type, trace_addr, trace_data
    );

    // Trace unit side: observes retire events, produces the trace stream.
    modport slave (
        input  RegWrite, WriteRegister, WriteData, MemRead, MemWrite,
               MemAddress, MemDataIn, MemDataOut, Halt,
               ICacheReq, ICacheHit, DCacheReq, DCacheHit, trace_ready,
        output trace_valid, trace_type, trace_addr, trace_data
    );
endinterface

// File: rtl/commit_trace_unit.sv
// Commit trace unit: packs retire events into trace records, buffers them in
// a FIFO, and after halt drains the FIFO, emits a halt record carrying the
// drop count, then twelve statistics half-word records, then parks in DONE.
module commit_trace_unit #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    commit_trace_unit_if.slave bus,
    output logic               overflow,
    output logic               done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [2:0] TYPE_REG   = 3'd0;
    localparam logic [2:0] TYPE_LOAD  = 3'd1;
    localparam logic [2:0] TYPE_STORE = 3'd2;
    localparam logic [2:0] TYPE_HALT  = 3'd3;
    localparam logic [2:0] TYPE_STAT  = 3'd4;
    localparam logic [3:0] LAST_STAT  = 4'd11;

    typedef enum logic [2:0] {RUN, DRAIN, HALTREC, STATS, DONE} stateType;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
    } traceRec;

    stateType         state, nextState;
    traceRec          fifoMem [DEPTH];
    traceRec          regRec, loadRec, storeRec, headRec, outRec;
    logic [PTR_W-1:0] wrPtr, rdPtr, loadOff, storeOff;
    logic [OCC_W-1:0] count, freeSlots;
    logic [1:0]       numRecs;
    logic             inRun, pushEn, dropEn, popEn, outValid;
    logic [CNT_W-1:0] cycleCnt, instCnt, dcHitCnt, icHitCnt, dcReqCnt, icReqCnt;
    logic [CNT_W-1:0] statVal;
    logic [15:0]      dropCount;
    logic [3:0]       statIdx;

    // Build this cycle's records and decide whether all of them fit.
    always_comb begin
        regRec    = '{kind: TYPE_REG,   addr: {13'b0, bus.WriteRegister}, data: bus.WriteData};
        loadRec   = '{kind: TYPE_LOAD,  addr: bus.MemAddress,             data: bus.MemDataOut};
        storeRec  = '{kind: TYPE_STORE, addr: bus.MemAddress,             data: bus.MemDataIn};
        numRecs   = 2'(bus.RegWrite) + 2'(bus.MemRead) + 2'(bus.MemWrite);
        loadOff   = PTR_W'(bus.RegWrite);
        storeOff  = PTR_W'(bus.RegWrite) + PTR_W'(bus.MemRead);
        // Free space is taken before any same-cycle pop.
        freeSlots = OCC_W'(DEPTH) - count;
        inRun     = (state == RUN);
        pushEn    = inRun && (numRecs != 2'd0) && (OCC_W'(numRecs) <= freeSlots);
        dropEn    = inRun && (numRecs != 2'd0) && !pushEn;
        popEn     = ((state == RUN) || (state == DRAIN)) && (count != '0) && bus.trace_ready;
    end

    // Record storage: an accepted cycle writes its records into consecutive slots.
    // NOTE: the storage array is deliberately not reset; count alone says which slots are live.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            if (bus.RegWrite) fifoMem[wrPtr]            <= regRec;
            if (bus.MemRead)  fifoMem[wrPtr + loadOff]  <= loadRec;
            if (bus.MemWrite) fifoMem[wrPtr + storeOff] <= storeRec;
        end
    end

    // FIFO pointers wrap modulo DEPTH; occupancy separates full from empty.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushEn) wrPtr <= wrPtr + PTR_W'(numRecs);
            if (popEn)  rdPtr <= rdPtr + PTR_W'(1);
            count <= count + OCC_W'(pushEn ? numRecs : 2'd0) - OCC_W'(popEn);
        end
    end

    // Statistics, drop count and sticky overflow advance only while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycleCnt  <= '0;
            instCnt   <= '0;
            dcHitCnt  <= '0;
            icHitCnt  <= '0;
            dcReqCnt  <= '0;
            icReqCnt  <= '0;
            dropCount <= '0;
            overflow  <= 1'b0;
        end else if (state == RUN) begin
            cycleCnt <= cycleCnt + CNT_W'(1);
            if (bus.Halt || bus.RegWrite || bus.MemWrite) instCnt <= instCnt + CNT_W'(1);
            if (bus.DCacheHit) dcHitCnt <= dcHitCnt + CNT_W'(1);
            if (bus.ICacheHit) icHitCnt <= icHitCnt + CNT_W'(1);
            if (bus.DCacheReq) dcReqCnt <= dcReqCnt + CNT_W'(1);
            if (bus.ICacheReq) icReqCnt <= icReqCnt + CNT_W'(1);
            if (dropEn) begin
                overflow <= 1'b1;
                if (dropCount != 16'hFFFF) dropCount <= dropCount + 16'd1;
            end
        end
    end

    // Statistics record index advances on each accepted stat record.
    always_ff @(posedge clk) begin
        if (rst) begin
            statIdx <= '0;
        end else if ((state == STATS) && bus.trace_ready) begin
            statIdx <= statIdx + 4'd1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= nextState;
    end

    // Next state and stream output: FIFO head in RUN/DRAIN, generated records after.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        nextState = state;
        outValid  = 1'b0;
        outRec    = '0;
        done      = 1'b0;
        headRec   = fifoMem[rdPtr];
        case (statIdx[3:1])
            3'd0:    statVal = cycleCnt;
            3'd1:    statVal = instCnt;
            3'd2:    statVal = dcHitCnt;
            3'd3:    statVal = icHitCnt;
            3'd4:    statVal = dcReqCnt;
            3'd5:    statVal = icReqCnt;
            default: statVal = '0;
        endcase
        case (state)
            RUN: begin
                if (count != '0) begin
                    outValid = 1'b1;
                    outRec   = headRec;
                end
                if (bus.Halt) nextState = DRAIN;
            end
            DRAIN: begin
                if (count != '0) begin
                    outValid = 1'b1;
                    outRec   = headRec;
                end else begin
                    nextState = HALTREC;
                end
            end
            HALTREC: begin
                outValid = 1'b1;
                outRec   = '{kind: TYPE_HALT, addr: 16'h0000, data: dropCount};
                if (bus.trace_ready) nextState = STATS;
            end
            STATS: begin
                // Even index selects the upper half (half flag 1), odd the lower.
                outValid = 1'b1;
                outRec   = '{kind: TYPE_STAT,
                             addr: {12'b0, statIdx[3:1], ~statIdx[0]},
                             data: statIdx[0] ? statVal[15:0] : statVal[31:16]};
                if (bus.trace_ready && (statIdx == LAST_STAT)) nextState = DONE;
            end
            DONE: begin
                done = 1'b1;
            end
            default: nextState = RUN;
        endcase
    end

    assign bus.trace_valid = outValid;
    assign bus.trace_type  = outRec.kind;
    assign bus.trace_addr  = outRec.addr;
    assign bus.trace_data  = outRec.data;
endmodule

// File: tb/tb_commit_trace_unit.sv
// Scoreboard bench for commit_trace_unit: stimulus pushes expected records
// from a behavioural model; a negedge monitor pops and compares on transfer.
module tb_commit_trace_unit;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] addr;
        logic [15:0] data;
    } recType;

    logic clk = 1'b0;
    logic rst;
    logic overflow, done;

    commit_trace_unit_if bus();

    commit_trace_unit #(.DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .overflow(overflow),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    recType      expQ[$];
    int          fifoOcc;
    int unsigned mCycles, mInst, mDcHit, mIcHit, mDcReq, mIcReq;
    int          mDrops;
    bit          mOvf;
    int          readyMode;   // 0 always ready, 1 random, 2 held low
    int          nChecks = 0;
    int          nErrors = 0;

    task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.RegWrite      = 1'b0;
        bus.WriteRegister = 3'd0;
        bus.WriteData     = 16'h0;
        bus.MemRead       = 1'b0;
        bus.MemWrite      = 1'b0;
        bus.MemAddress    = 16'h0;
        bus.MemDataIn     = 16'h0;
        bus.MemDataOut    = 16'h0;
        bus.Halt          = 1'b0;
        bus.ICacheReq     = 1'b0;
        bus.ICacheHit     = 1'b0;
        bus.DCacheReq     = 1'b0;
        bus.DCacheHit     = 1'b0;
    endtask

    task automatic clearModel();
        expQ.delete();
        fifoOcc = 0;
        mCycles = 0; mInst = 0; mDcHit = 0; mIcHit = 0; mDcReq = 0; mIcReq = 0;
        mDrops  = 0;
        mOvf    = 1'b0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        idleInputs();
        clearModel();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic pushRec(logic [2:0] kind, logic [15:0] addr, logic [15:0] data);
        recType r;
        r.kind = kind;
        r.addr = addr;
        r.data = data;
        expQ.push_back(r);
    endtask

    // Apply the model to the inputs currently driven, then advance one cycle.
    task automatic step();
        int n;
        int unsigned vals[6];
        n = int'(bus.RegWrite) + int'(bus.MemRead) + int'(bus.MemWrite);
        if (n > 0) begin
            if (n <= DEPTH - fifoOcc) begin
                if (bus.RegWrite) pushRec(3'd0, {13'b0, bus.WriteRegister}, bus.WriteData);
                if (bus.MemRead)  pushRec(3'd1, bus.MemAddress, bus.MemDataOut);
                if (bus.MemWrite) pushRec(3'd2, bus.MemAddress, bus.MemDataIn);
                fifoOcc += n;
            end else begin
                mOvf = 1'b1;
                if (mDrops < 65535) mDrops++;
            end
        end
        mCycles++;
        if (bus.Halt || bus.RegWrite || bus.MemWrite) mInst++;
        if (bus.DCacheHit) mDcHit++;
        if (bus.ICacheHit) mIcHit++;
        if (bus.DCacheReq) mDcReq++;
        if (bus.ICacheReq) mIcReq++;
        if (bus.Halt) begin
            pushRec(3'd3, 16'h0000, 16'(mDrops));
            vals = '{mCycles, mInst, mDcHit, mIcHit, mDcReq, mIcReq};
            for (int i = 0; i < 6; i++) begin
                pushRec(3'd4, 16'(i * 2 + 1), vals[i][31:16]);
                pushRec(3'd4, 16'(i * 2),     vals[i][15:0]);
            end
        end
        tick();
        idleInputs();
        check("overflow_flag", overflow, mOvf);
    endtask

    task automatic waitQueue(string name, int target, int budget);
        for (int i = 0; i < budget && expQ.size() > target; i++) tick();
        if (expQ.size() > target) check(name, expQ.size(), target);
    endtask

    task automatic waitDone(string name);
        waitQueue(name, 0, 3000);
        tick();
        check({name, "_done"}, done, 1'b1);
        check({name, "_valid_off"}, bus.trace_valid, 1'b0);
    endtask

    task automatic threeRec(logic [15:0] base);
        bus.RegWrite      = 1'b1;
        bus.WriteRegister = base[2:0];
        bus.WriteData     = base ^ 16'h1111;
        bus.MemRead       = 1'b1;
        bus.MemWrite      = 1'b1;
        bus.MemAddress    = base + 16'h0040;
        bus.MemDataOut    = base ^ 16'h2222;
        bus.MemDataIn     = base ^ 16'h3333;
    endtask

    task automatic randomInputs();
        bus.RegWrite      = ($urandom_range(0, 99) < 60);
        bus.WriteRegister = 3'($urandom);
        bus.WriteData     = 16'($urandom);
        bus.MemRead       = ($urandom_range(0, 99) < 40);
        bus.MemWrite      = ($urandom_range(0, 99) < 40);
        bus.MemAddress    = 16'($urandom);
        bus.MemDataIn     = 16'($urandom);
        bus.MemDataOut    = 16'($urandom);
        bus.ICacheReq     = 1'($urandom);
        bus.ICacheHit     = bus.ICacheReq & 1'($urandom);
        bus.DCacheReq     = 1'($urandom);
        bus.DCacheHit     = bus.DCacheReq & 1'($urandom);
    endtask

    // Ready driver.
    initial begin
        bus.trace_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       bus.trace_ready = 1'b1;
                1:       bus.trace_ready = ($urandom_range(0, 3) != 0);
                default: bus.trace_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compares each transfer against the scoreboard and checks stall stability.
    initial begin
        recType cur, held, exp;
        bit stalled;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                cur.kind = bus.trace_type;
                cur.addr = bus.trace_addr;
                cur.data = bus.trace_data;
                if (stalled) begin
                    check("stall_valid_held", bus.trace_valid, 1'b1);
                    if (bus.trace_valid) begin
                        check("stall_type_held", cur.kind, held.kind);
                        check("stall_addr_held", cur.addr, held.addr);
                        check("stall_data_held", cur.data, held.data);
                    end
                end
                stalled = 1'b0;
                if (bus.trace_valid && bus.trace_ready) begin
                    if (expQ.size() == 0) begin
                        nChecks++;
                        nErrors++;
                        $display("FAIL unexpected_record: got type %0d addr 0x%0h data 0x%0h, expected none",
                                 cur.kind, cur.addr, cur.data);
                    end else begin
                        exp = expQ.pop_front();
                        check("rec_type", cur.kind, exp.kind);
                        check("rec_addr", cur.addr, exp.addr);
                        check("rec_data", cur.data, exp.data);
                        if (exp.kind < 3'd3) fifoOcc--;
                    end
                end else if (bus.trace_valid) begin
                    stalled = 1'b1;
                    held    = cur;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        readyMode = 0;
        rst = 1'b1;
        idleInputs();

        // Scenario 1: reset state, single-record latency, three records in one cycle.
        resetDut();
        check("rst_valid",    bus.trace_valid, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_done",     done, 1'b0);
        check("rst_type",     bus.trace_type, 3'd0);
        check("rst_addr",     bus.trace_addr, 16'h0);
        check("rst_data",     bus.trace_data, 16'h0);
        bus.RegWrite = 1'b1; bus.WriteRegister = 3'd3; bus.WriteData = 16'hBEEF;
        step();
        check("lat_valid", bus.trace_valid, 1'b1);
        check("lat_addr",  bus.trace_addr, 16'h0003);
        check("lat_data",  bus.trace_data, 16'hBEEF);
        step();
        check("lat_valid_drop", bus.trace_valid, 1'b0);
        bus.RegWrite = 1'b1; bus.WriteRegister = 3'd1; bus.WriteData = 16'h1111;
        bus.MemRead  = 1'b1; bus.MemAddress = 16'h0040; bus.MemDataOut = 16'h2222;
        bus.MemWrite = 1'b1; bus.MemDataIn = 16'h3333;
        step();
        repeat (4) step();
        bus.Halt = 1'b1;
        step();
        waitDone("scn1");

        // Scenario 2: overflow with a stalled consumer, then drain.
        resetDut();
        readyMode = 2; bus.trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            threeRec(16'(i * 16'h0101));
            step();
        end
        readyMode = 0; bus.trace_ready = 1'b1;
        bus.Halt = 1'b1;
        step();
        waitDone("scn2");
        check("scn2_overflow_sticky", overflow, 1'b1);

        // Scenario 3: counters from reset, then a three-cycle stall during STATS.
        resetDut();
        for (int i = 0; i < 6; i++) begin
            bus.RegWrite      = (i < 4);
            bus.WriteRegister = 3'(i);
            bus.WriteData     = 16'(16'hA000 + i);
            bus.ICacheReq     = 1'b1;
            bus.ICacheHit     = (i == 0) || (i == 2) || (i == 4);
            bus.Halt          = (i == 5);
            step();
        end
        waitQueue("scn3_reach_stats", 10, 200);
        readyMode = 2; bus.trace_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("scn3_stall_valid", bus.trace_valid, 1'b1);
        end
        readyMode = 0; bus.trace_ready = 1'b1;
        waitDone("scn3");

        // Scenario 4: randomized traffic with a random consumer.
        resetDut();
        readyMode = 1;
        for (int i = 0; i < 400; i++) begin
            randomInputs();
            bus.Halt = (i == 399);
            step();
        end
        waitDone("scn4");

        // Scenario 5: reset asserted during STATS, then a fresh run.
        resetDut();
        readyMode = 2; bus.trace_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            threeRec(16'(16'h0F00 + i));
            step();
        end
        readyMode = 0; bus.trace_ready = 1'b1;
        bus.Halt = 1'b1;
        step();
        waitQueue("scn5_reach_stats", 6, 300);
        rst = 1'b1;
        clearModel();
        tick();
        check("scn5_rst_valid",    bus.trace_valid, 1'b0);
        check("scn5_rst_done",     done, 1'b0);
        check("scn5_rst_overflow", overflow, 1'b0);
        rst = 1'b0;
        bus.RegWrite = 1'b1; bus.WriteRegister = 3'd5; bus.WriteData = 16'h5A5A;
        step();
        step();
        bus.Halt = 1'b1;
        step();
        waitDone("scn5");

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end
endmodule
